// File: rtl/touch_led_ctrl.sv
// Touch-key LED mode controller: synchronizes and debounces a capacitive touch level,
// classifies presses as short/long, and steps the LED through off/on/slow/fast blink.
module touch_led_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int SLOW_HALF    = 25_000_000,
  parameter int FAST_HALF    = 6_250_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       touch,
  output logic       led,
  output logic [1:0] mode,
  output logic       short_press,
  output logic       long_press
);

  localparam int DW   = $clog2(DEBOUNCE_CYC);
  localparam int HW   = $clog2(LONG_CYC);
  localparam int BMAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int BW   = $clog2(BMAX);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_ON   = 2'd1;
  localparam logic [1:0] MODE_SLOW = 2'd2;

  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

  logic          s0_q, s0_d, s1_q, s1_d;
  logic          db_q, db_d, db_dly_q, db_dly_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          short_q, short_d, long_q, long_d;
  logic [BW-1:0] bcnt_q, bcnt_d, half_last;
  logic          phase_q, phase_d;
  logic          led_q, led_d;
  logic          rise, fall;

  always_comb begin
    s0_d     = touch;
    s1_d     = s0_q;
    db_d     = db_q;
    dcnt_d   = '0;
    db_dly_d = db_q;
    if (s1_q != db_q) begin
      if (dcnt_q == DB_LAST) db_d = s1_q;
      else                   dcnt_d = dcnt_q + 1'b1;
    end

    rise = db_q & ~db_dly_q;
    fall = ~db_q & db_dly_q;

    // A release on the terminal hold cycle still counts as a short press.
    state_d = state_q;
    hcnt_d  = hcnt_q;
    mode_d  = mode_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          hcnt_d  = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d = IDLE;
          short_d = 1'b1;
          mode_d  = mode_q + 2'd1;
        end else if (hcnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          mode_d  = MODE_OFF;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      LONG_HELD: if (fall) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Restarting the blink on a mode change makes the first phase a full high half-period.
    half_last = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
    bcnt_d    = '0;
    phase_d   = phase_q;
    if (mode_d != mode_q) begin
      phase_d = 1'b1;
    end else if (mode_q[1]) begin
      if (bcnt_q == half_last) phase_d = ~phase_q;
      else                     bcnt_d  = bcnt_q + 1'b1;
    end

    case (mode_q)
      MODE_OFF: led_d = 1'b0;
      MODE_ON:  led_d = 1'b1;
      default:  led_d = phase_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      dcnt_q   <= '0;
      state_q  <= IDLE;
      hcnt_q   <= '0;
      mode_q   <= MODE_OFF;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
      led_q    <= 1'b0;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      dcnt_q   <= dcnt_d;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      mode_q   <= mode_d;
      short_q  <= short_d;
      long_q   <= long_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end

  assign led         = led_q;
  assign mode        = mode_q;
  assign short_press = short_q;
  assign long_press  = long_q;

endmodule

// File: tb/tb_touch_led_ctrl.sv
// Bench for touch_led_ctrl: table of presses with expected pulses queued on a scoreboard,
// plus hand sequences for blink timing and reset during a hold.
module tb_touch_led_ctrl;

  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int SLOW = 8;
  localparam int FAST = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       touch = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       short_press, long_press;

  touch_led_ctrl #(
    .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .SLOW_HALF(SLOW), .FAST_HALF(FAST)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .touch(touch), .led(led),
    .mode(mode), .short_press(short_press), .long_press(long_press)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {int kind; int at; logic [1:0] mode;} ev_t;  // kind: 1 short, 2 long
  ev_t sb[$];

  typedef struct {int hold; int gap; int kind; logic [1:0] mode; int led;} vec_t;
  vec_t vecs[11];

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Touch goes high just after edge N0; expected pulse timing follows from debounce/hold latency.
  task automatic press(input int hold, input int kind, input logic [1:0] exp_mode);
    ev_t e;
    int n0;
    n0 = cyc;
    if (kind != 0) begin
      e.kind = kind;
      e.mode = exp_mode;
      e.at   = (kind == 2) ? n0 + DEB + 2 + LNG + 1 : n0 + hold + DEB + 3;
      sb.push_back(e);
    end
    touch = 1'b1;
    wait_cyc(hold);
    touch = 1'b0;
  endtask

  task automatic check_blink(input int m, input int half, input int n, input string name);
    int guard;
    guard = 0;
    @(negedge sys_clk);
    while (cyc != m + 1 && guard < 200) begin
      @(negedge sys_clk);
      guard++;
    end
    chk({name, "_sync"}, cyc, m + 1);
    for (int k = 0; k < n; k++) begin
      chk(name, led, ((k / half) % 2 == 0) ? 1 : 0);
      @(negedge sys_clk);
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    ev_t e;
    int ak;
    forever begin
      @(negedge sys_clk);
      if (short_press && long_press) chk("pulse_excl", 1, 0);
      if (short_press || long_press) begin
        ak = short_press ? 1 : 2;
        if (sb.size() == 0) begin
          chk("unexpected_pulse", ak, 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", ak, e.kind);
          chk("pulse_cyc", cyc, e.at);
          chk("pulse_mode", mode, e.mode);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m;
    vecs[0]  = '{3,  15, 0, 2'd0, 0};   // glitch rejected
    vecs[1]  = '{10, 15, 1, 2'd1, 1};
    vecs[2]  = '{10, 15, 1, 2'd2, -1};
    vecs[3]  = '{10, 15, 1, 2'd3, -1};
    vecs[4]  = '{10, 15, 1, 2'd0, 0};   // wrap 3 -> 0
    vecs[5]  = '{4,  15, 1, 2'd1, 1};   // shortest accepted press
    vecs[6]  = '{10, 15, 1, 2'd2, -1};
    vecs[7]  = '{40, 15, 2, 2'd0, 0};   // long press from SLOW
    vecs[8]  = '{20, 15, 1, 2'd1, 1};   // fall on terminal hold cycle
    vecs[9]  = '{21, 15, 2, 2'd0, 0};   // one cycle longer -> long
    vecs[10] = '{10, 15, 1, 2'd1, 1};

    // Reset held with touch toggling
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk);
      #1;
      touch = ~touch;
      if (i % 3 == 0) begin
        chk("rst_led", led, 0);
        chk("rst_mode", mode, 0);
        chk("rst_pulses", {short_press, long_press}, 0);
      end
    end
    touch = 1'b0;
    wait_cyc(2);
    sys_rst_n = 1'b1;
    wait_cyc(12);
    chk("post_rst_led", led, 0);
    chk("post_rst_mode", mode, 0);

    for (int i = 0; i < 11; i++) begin
      press(vecs[i].hold, vecs[i].kind, vecs[i].mode);
      wait_cyc(vecs[i].gap);
      chk($sformatf("v%0d_mode", i), mode, vecs[i].mode);
      if (vecs[i].led >= 0) chk($sformatf("v%0d_led", i), led, vecs[i].led);
      chk($sformatf("v%0d_sb_drained", i), sb.size(), 0);
    end

    // SLOW blink: mode changes on edge m, led follows from m+1
    n0 = cyc;
    m  = n0 + 10 + DEB + 3;
    press(10, 1, 2'd2);
    check_blink(m, SLOW, 3 * SLOW, "slow_blink");
    chk("slow_mode", mode, 2);

    // FAST blink
    n0 = cyc;
    m  = n0 + 10 + DEB + 3;
    press(10, 1, 2'd3);
    check_blink(m, FAST, 6 * FAST, "fast_blink");
    chk("fast_mode", mode, 3);

    // Reset in the middle of a hold (PRESSED, well before LONG_CYC)
    touch = 1'b1;
    wait_cyc(15);
    sys_rst_n = 1'b0;
    #1;
    chk("midhold_rst_mode", mode, 0);
    chk("midhold_rst_led", led, 0);
    touch = 1'b0;
    wait_cyc(3);
    sys_rst_n = 1'b1;
    wait_cyc(40);
    chk("after_midhold_mode", mode, 0);
    chk("after_midhold_led", led, 0);
    chk("final_sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
